// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_types_pkg
// Brief    : Shared word type, coherence bus states and block helpers.
// Revision : 1.0
// ============================================================================
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam int CC_BLKOFF_W = 3;

  typedef enum logic [3:0] {
    IDLE,
    WB1,
    WB2,
    SNOOP,
    RD1,
    RD2,
    C2C1,
    C2C2,
    INVAL,
    IFETCH
  } ccstate_t;

  // Word address within a two-word block: sel=0 first word, sel=1 second word.
  function automatic word_t blk_word(input word_t addr, input logic sel);
    return {addr[31:CC_BLKOFF_W], sel, 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin pick; search starts after last_grant.
// Revision : 1.0
// ============================================================================
module rr_arbiter #(
  parameter  int CPUS  = 2,
  localparam int IDX_W = (CPUS > 1) ? $clog2(CPUS) : 1
) (
  input  logic [CPUS-1:0]  req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [IDX_W-1:0] grant,
  output logic             valid
);

  int w_idx;

  // Walk from farthest to nearest so the core right after last_grant wins.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    w_idx = 0;
    for (int k = CPUS; k >= 1; k--) begin
      w_idx = (int'(last_grant) + k) % CPUS;
      if (req[w_idx[IDX_W-1:0]]) begin
        grant = w_idx[IDX_W-1:0];
        valid = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/coherence_controller.sv
`default_nettype none
// ============================================================================
// Module   : coherence_controller
// Brief    : Shared RAM bus arbiter plus MSI snoop / cache-to-cache sequencer.
//            Optional BUS_STATS_EN adds snoop_hits and c2c_dirty counters.
// Revision : 1.0
// ============================================================================
module coherence_controller
  import cpu_types_pkg::*;
#(
  parameter int CPUS   = 2,
  parameter int WORD_W = 32
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic [CPUS-1:0]        iREN,
  input  logic [CPUS*WORD_W-1:0] iaddr,
  output logic [CPUS-1:0]        iwait,
  output logic [CPUS*WORD_W-1:0] iload,
  input  logic [CPUS-1:0]        dREN,
  input  logic [CPUS-1:0]        dWEN,
  input  logic [CPUS*WORD_W-1:0] daddr,
  input  logic [CPUS*WORD_W-1:0] dstore,
  output logic [CPUS-1:0]        dwait,
  output logic [CPUS*WORD_W-1:0] dload,
  input  logic [CPUS-1:0]        cctrans,
  input  logic [CPUS-1:0]        ccwrite,
  output logic [CPUS-1:0]        ccwait,
  output logic [CPUS-1:0]        ccinv,
  output logic [CPUS*WORD_W-1:0] ccsnoopaddr,
  output logic                   ramREN,
  output logic                   ramWEN,
  output logic [WORD_W-1:0]      ramaddr,
  output logic [WORD_W-1:0]      ramstore,
  input  logic [WORD_W-1:0]      ramload,
  input  logic                   ramwait
`ifdef BUS_STATS_EN
  ,
  output logic [31:0]            snoop_hits,
  output logic [31:0]            c2c_dirty
`endif
);

  localparam int IDX_W   = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam int C_NCLS  = 4;

  ccstate_t          r_state;
  logic [IDX_W-1:0]  r_owner;
  logic [IDX_W-1:0]  r_last_grant;
  logic              r_dirty;
  logic              r_c2c_wait;

  logic [IDX_W-1:0]  w_other;
  logic [CPUS-1:0]   w_req   [C_NCLS];
  logic [IDX_W-1:0]  w_grant [C_NCLS];
  logic [C_NCLS-1:0] w_valid;
  logic [WORD_W-1:0] w_own_daddr;
  logic [WORD_W-1:0] w_own_dstore;
  logic [WORD_W-1:0] w_own_iaddr;
  logic [WORD_W-1:0] w_oth_dstore;
  logic [WORD_W-1:0] w_blk_addr;
  logic              w_c2c_done;
  int                w_own_lsb;
  int                w_oth_lsb;

  assign w_other      = ~r_owner;
  assign w_own_lsb    = int'(r_owner) * WORD_W;
  assign w_oth_lsb    = int'(w_other) * WORD_W;
  assign w_own_daddr  = daddr[w_own_lsb +: WORD_W];
  assign w_own_dstore = dstore[w_own_lsb +: WORD_W];
  assign w_own_iaddr  = iaddr[w_own_lsb +: WORD_W];
  assign w_oth_dstore = dstore[w_oth_lsb +: WORD_W];
  assign w_blk_addr   = blk_word(w_own_daddr, r_state == C2C2);
  // A clean transfer has no RAM handshake; it spends one wait cycle instead.
  assign w_c2c_done   = r_dirty ? ~ramwait : r_c2c_wait;

  // Request classes in priority order: writeback, coherent read, upgrade, ifetch.
  assign w_req[0] = dWEN;
  assign w_req[1] = cctrans & dREN;
  assign w_req[2] = cctrans & ccwrite & ~dREN & ~dWEN;
  assign w_req[3] = iREN;

  generate
    for (genvar g = 0; g < C_NCLS; g++) begin : g_arb
      rr_arbiter #(.CPUS(CPUS)) u_arb (
        .req        (w_req[g]),
        .last_grant (r_last_grant),
        .grant      (w_grant[g]),
        .valid      (w_valid[g])
      );
    end
  endgenerate

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state      <= IDLE;
      r_owner      <= '0;
      r_last_grant <= '0;
      r_dirty      <= 1'b0;
      r_c2c_wait   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_valid[0]) begin
            r_owner      <= w_grant[0];
            r_last_grant <= w_grant[0];
            r_state      <= WB1;
          end else if (w_valid[1]) begin
            r_owner      <= w_grant[1];
            r_last_grant <= w_grant[1];
            r_state      <= SNOOP;
          end else if (w_valid[2]) begin
            r_owner      <= w_grant[2];
            r_last_grant <= w_grant[2];
            r_state      <= INVAL;
          end else if (w_valid[3]) begin
            r_owner      <= w_grant[3];
            r_last_grant <= w_grant[3];
            r_state      <= IFETCH;
          end
        end
        WB1:    if (!ramwait) r_state <= WB2;
        WB2:    if (!ramwait) r_state <= IDLE;
        SNOOP: begin
          r_dirty    <= ccwrite[w_other];
          r_c2c_wait <= 1'b0;
          r_state    <= cctrans[w_other] ? C2C1 : RD1;
        end
        RD1:    if (!ramwait) r_state <= RD2;
        RD2:    if (!ramwait) r_state <= IDLE;
        C2C1, C2C2: begin
          if (w_c2c_done) begin
            r_c2c_wait <= 1'b0;
            r_state    <= (r_state == C2C1) ? C2C2 : IDLE;
          end else begin
            r_c2c_wait <= 1'b1;
          end
        end
        INVAL:  r_state <= IDLE;
        IFETCH: if (!ramwait) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    iwait       = '1;
    iload       = '0;
    dwait       = '1;
    dload       = '0;
    ccwait      = '0;
    ccinv       = '0;
    ccsnoopaddr = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    case (r_state)
      WB1, WB2: begin
        ramWEN   = 1'b1;
        ramaddr  = w_own_daddr;
        ramstore = w_own_dstore;
        if (!ramwait) dwait[r_owner] = 1'b0;
      end
      SNOOP: begin
        ccwait[w_other]                     = 1'b1;
        ccsnoopaddr[w_oth_lsb +: WORD_W]    = w_own_daddr;
      end
      RD1, RD2: begin
        ramREN                        = 1'b1;
        ramaddr                       = w_own_daddr;
        dload[w_own_lsb +: WORD_W]    = ramload;
        if (!ramwait) dwait[r_owner] = 1'b0;
        if (r_state == RD2 && ccwrite[r_owner]) begin
          ccinv[w_other]  = 1'b1;
          ccwait[w_other] = 1'b1;
        end
      end
      C2C1, C2C2: begin
        ccwait[w_other]                  = 1'b1;
        dload[w_own_lsb +: WORD_W]       = w_oth_dstore;
        ccsnoopaddr[w_oth_lsb +: WORD_W] = w_blk_addr;
        ramaddr                          = w_blk_addr;
        if (r_dirty) begin
          ramWEN   = 1'b1;
          ramstore = w_oth_dstore;
        end
        // Snoopee also sees dwait low so its writeback-to-cache states advance.
        if (w_c2c_done) begin
          dwait[r_owner] = 1'b0;
          dwait[w_other] = 1'b0;
          if (r_state == C2C2) ccinv[w_other] = ccwrite[r_owner];
        end
      end
      INVAL: begin
        ccwait[w_other]                  = 1'b1;
        ccinv[w_other]                   = 1'b1;
        ccsnoopaddr[w_oth_lsb +: WORD_W] = w_own_daddr;
        dwait[r_owner]                   = 1'b0;
      end
      IFETCH: begin
        ramREN                     = 1'b1;
        ramaddr                    = w_own_iaddr;
        iload[w_own_lsb +: WORD_W] = ramload;
        if (!ramwait) iwait[r_owner] = 1'b0;
      end
      default: ;
    endcase
  end

`ifdef BUS_STATS_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      snoop_hits <= '0;
      c2c_dirty  <= '0;
    end else if (r_state == SNOOP) begin
      if (cctrans[w_other] && snoop_hits != '1) snoop_hits <= snoop_hits + 32'd1;
      if (ccwrite[w_other] && c2c_dirty != '1)  c2c_dirty  <= c2c_dirty + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_coherence_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_coherence_controller
// Brief    : Directed vector table for grant outcomes plus multi-cycle sequences.
// Revision : 1.0
// ============================================================================
module tb_coherence_controller;

  logic        CLK, nRST;
  logic [1:0]  iREN, dREN, dWEN, cctrans, ccwrite;
  logic [63:0] iaddr, daddr, dstore;
  logic [1:0]  iwait, dwait, ccwait, ccinv;
  logic [63:0] iload, dload, ccsnoopaddr;
  logic        ramREN, ramWEN, ramwait;
  logic [31:0] ramaddr, ramstore, ramload;
`ifdef BUS_STATS_EN
  logic [31:0] snoop_hits, c2c_dirty;
`endif

  int checks   = 0;
  int failures = 0;

  coherence_controller #(.CPUS(2), .WORD_W(32)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .cctrans(cctrans), .ccwrite(ccwrite), .ccwait(ccwait), .ccinv(ccinv),
    .ccsnoopaddr(ccsnoopaddr),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramwait(ramwait)
`ifdef BUS_STATS_EN
    , .snoop_hits(snoop_hits), .c2c_dirty(c2c_dirty)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [1:0]  dwen, dren, cct, ccw, iren;
    logic        ren, wen;
    logic [31:0] addr, store;
    logic [1:0]  dwait, iwait, ccwait, ccinv;
    logic [63:0] snoop;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic clear_req();
    iREN = '0; dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0;
  endtask

  task automatic do_reset();
    clear_req();
    daddr  = {32'h208, 32'h100};
    dstore = {32'h66, 32'h55};
    nRST = 1'b0;
    step();
    nRST = 1'b1;
  endtask

  initial begin
    iaddr   = {32'h504, 32'h400};
    ramload = 32'h0;
    ramwait = 1'b0;
    do_reset();

    //             dwen  dren  cct   ccw   iren  ren wen addr      store    dwait iwait ccwait ccinv snoop
    vecs[0]  = '{2'b00,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0,32'h0,  32'h0, 2'b11,2'b11,2'b00,2'b00,64'h0};
    vecs[1]  = '{2'b00,2'b00,2'b00,2'b00,2'b11,1'b1,1'b0,32'h504,32'h0, 2'b11,2'b11,2'b00,2'b00,64'h0};
    vecs[2]  = '{2'b00,2'b00,2'b00,2'b00,2'b01,1'b1,1'b0,32'h400,32'h0, 2'b11,2'b11,2'b00,2'b00,64'h0};
    vecs[3]  = '{2'b11,2'b00,2'b00,2'b00,2'b00,1'b0,1'b1,32'h208,32'h66,2'b11,2'b11,2'b00,2'b00,64'h0};
    vecs[4]  = '{2'b01,2'b00,2'b00,2'b00,2'b11,1'b0,1'b1,32'h100,32'h55,2'b11,2'b11,2'b00,2'b00,64'h0};
    vecs[5]  = '{2'b00,2'b01,2'b01,2'b00,2'b00,1'b0,1'b0,32'h0,  32'h0, 2'b11,2'b11,2'b10,2'b00,{32'h100,32'h0}};
    vecs[6]  = '{2'b00,2'b11,2'b11,2'b00,2'b00,1'b0,1'b0,32'h0,  32'h0, 2'b11,2'b11,2'b01,2'b00,{32'h0,32'h208}};
    vecs[7]  = '{2'b00,2'b10,2'b01,2'b00,2'b00,1'b0,1'b0,32'h0,  32'h0, 2'b11,2'b11,2'b00,2'b00,64'h0};
    vecs[8]  = '{2'b00,2'b00,2'b10,2'b10,2'b00,1'b0,1'b0,32'h0,  32'h0, 2'b01,2'b11,2'b01,2'b01,{32'h0,32'h208}};
    vecs[9]  = '{2'b00,2'b01,2'b01,2'b01,2'b00,1'b0,1'b0,32'h0,  32'h0, 2'b11,2'b11,2'b10,2'b00,{32'h100,32'h0}};
    vecs[10] = '{2'b00,2'b01,2'b11,2'b10,2'b00,1'b0,1'b0,32'h0,  32'h0, 2'b11,2'b11,2'b10,2'b00,{32'h100,32'h0}};
    vecs[11] = '{2'b10,2'b01,2'b01,2'b00,2'b00,1'b0,1'b1,32'h208,32'h66,2'b11,2'b11,2'b00,2'b00,64'h0};
    vecs[12] = '{2'b00,2'b00,2'b01,2'b01,2'b10,1'b0,1'b0,32'h0,  32'h0, 2'b10,2'b11,2'b10,2'b10,{32'h100,32'h0}};
    vecs[13] = '{2'b00,2'b00,2'b00,2'b11,2'b00,1'b0,1'b0,32'h0,  32'h0, 2'b11,2'b11,2'b00,2'b00,64'h0};

    // Reset state before any request.
    @(negedge CLK);
    chk("reset_dwait", dwait, 2'b11);
    chk("reset_iwait", iwait, 2'b11);
    chk("reset_ramREN", ramREN, 1'b0);

    // Grant outcome from reset, observed in the first post-grant cycle with RAM stalled.
    for (int v = 0; v < 14; v++) begin
      do_reset();
      ramwait = 1'b1;
      dWEN = vecs[v].dwen; dREN = vecs[v].dren; cctrans = vecs[v].cct;
      ccwrite = vecs[v].ccw; iREN = vecs[v].iren;
      step();
      @(negedge CLK);
      chk($sformatf("v%0d_ramREN", v),   ramREN,      vecs[v].ren);
      chk($sformatf("v%0d_ramWEN", v),   ramWEN,      vecs[v].wen);
      chk($sformatf("v%0d_ramaddr", v),  ramaddr,     vecs[v].addr);
      chk($sformatf("v%0d_ramstore", v), ramstore,    vecs[v].store);
      chk($sformatf("v%0d_dwait", v),    dwait,       vecs[v].dwait);
      chk($sformatf("v%0d_iwait", v),    iwait,       vecs[v].iwait);
      chk($sformatf("v%0d_ccwait", v),   ccwait,      vecs[v].ccwait);
      chk($sformatf("v%0d_ccinv", v),    ccinv,       vecs[v].ccinv);
      chk($sformatf("v%0d_snoop", v),    ccsnoopaddr, vecs[v].snoop);
    end

    // I-fetch contention: core1 first, then core0.
    do_reset();
    ramwait = 1'b0; ramload = 32'hC0DE; iREN = 2'b11;
    @(negedge CLK); chk("if_c1_iwait", iwait, 2'b11);
    step();
    @(negedge CLK);
    chk("if_c2_iwait", iwait, 2'b01);
    chk("if_c2_iload", iload, {32'hC0DE, 32'h0});
    chk("if_c2_addr", ramaddr, 32'h504);
    step(); iREN = 2'b01;
    @(negedge CLK); chk("if_c3_iwait", iwait, 2'b11);
    step();
    @(negedge CLK);
    chk("if_c4_iwait", iwait, 2'b10);
    chk("if_c4_addr", ramaddr, 32'h400);
    step(); clear_req();

    // Clean miss: snoop misses, two RAM reads.
    do_reset();
    ramwait = 1'b0; ramload = 32'hA; dREN = 2'b01; cctrans = 2'b01;
    step();
    @(negedge CLK);
    chk("cm_snoop_ccwait", ccwait, 2'b10);
    chk("cm_snoop_addr", ccsnoopaddr, {32'h100, 32'h0});
    step();
    @(negedge CLK);
    chk("cm_rd1_ren", ramREN, 1'b1);
    chk("cm_rd1_addr", ramaddr, 32'h100);
    chk("cm_rd1_dload", dload, {32'h0, 32'hA});
    chk("cm_rd1_dwait", dwait, 2'b10);
    step(); daddr[31:0] = 32'h104; ramload = 32'hB;
    @(negedge CLK);
    chk("cm_rd2_addr", ramaddr, 32'h104);
    chk("cm_rd2_dload", dload, {32'h0, 32'hB});
    chk("cm_rd2_dwait", dwait, 2'b10);
    chk("cm_rd2_ccinv", ccinv, 2'b00);
    step(); clear_req();
    @(negedge CLK);
    chk("cm_idle_ren", ramREN, 1'b0);
    chk("cm_idle_dwait", dwait, 2'b11);

    // Reset asserted while stalled in RD2.
    do_reset();
    ramwait = 1'b1; dREN = 2'b01; cctrans = 2'b01;
    step(); step();
    ramwait = 1'b0;
    step();
    ramwait = 1'b1;
    @(negedge CLK); chk("rst_rd2_ren", ramREN, 1'b1);
    #1 nRST = 1'b0;
    #1;
    chk("rst_dwait", dwait, 2'b11);
    chk("rst_ren", ramREN, 1'b0);
    step(); clear_req(); nRST = 1'b1;
    step();
    @(negedge CLK); chk("rst_after_ren", ramREN, 1'b0);

    // Dirty cache-to-cache with exclusive intent.
    do_reset();
    ramwait = 1'b0; daddr[31:0] = 32'h104; dstore[63:32] = 32'h11;
    dREN = 2'b01; cctrans = 2'b11; ccwrite = 2'b11;
    step();
    @(negedge CLK);
    chk("dc_snoop_addr", ccsnoopaddr, {32'h104, 32'h0});
    step();
    @(negedge CLK);
    chk("dc_c1_wen", ramWEN, 1'b1);
    chk("dc_c1_addr", ramaddr, 32'h100);
    chk("dc_c1_store", ramstore, 32'h11);
    chk("dc_c1_dload", dload, {32'h0, 32'h11});
    chk("dc_c1_dwait", dwait, 2'b00);
    chk("dc_c1_ccwait", ccwait, 2'b10);
    chk("dc_c1_ccinv", ccinv, 2'b00);
    chk("dc_c1_snoop", ccsnoopaddr, {32'h100, 32'h0});
    step(); dstore[63:32] = 32'h22;
    @(negedge CLK);
    chk("dc_c2_addr", ramaddr, 32'h104);
    chk("dc_c2_store", ramstore, 32'h22);
    chk("dc_c2_dload", dload, {32'h0, 32'h22});
    chk("dc_c2_dwait", dwait, 2'b00);
    chk("dc_c2_ccinv", ccinv, 2'b10);
    step(); clear_req();
    @(negedge CLK); chk("dc_idle_wen", ramWEN, 1'b0);

    // Clean cache-to-cache: one wait cycle per word, no RAM traffic.
    do_reset();
    ramwait = 1'b1; dstore[63:32] = 32'h33;
    dREN = 2'b01; cctrans = 2'b11;
    step(); step();
    @(negedge CLK);
    chk("cc_c1a_dwait", dwait, 2'b11);
    chk("cc_c1a_wen", ramWEN, 1'b0);
    chk("cc_c1a_ccwait", ccwait, 2'b10);
    step();
    @(negedge CLK);
    chk("cc_c1b_dwait", dwait, 2'b00);
    chk("cc_c1b_dload", dload, {32'h0, 32'h33});
    chk("cc_c1b_addr", ramaddr, 32'h100);
    step();
    @(negedge CLK); chk("cc_c2a_dwait", dwait, 2'b11);
    step();
    @(negedge CLK);
    chk("cc_c2b_dwait", dwait, 2'b00);
    chk("cc_c2b_addr", ramaddr, 32'h104);
    chk("cc_c2b_ccinv", ccinv, 2'b00);
    step(); clear_req();

    // Writeback beats a coherent read raised in the same cycle.
    do_reset();
    ramwait = 1'b0; dWEN = 2'b10; dREN = 2'b01; cctrans = 2'b01;
    step();
    @(negedge CLK);
    chk("pr_wb1_wen", ramWEN, 1'b1);
    chk("pr_wb1_addr", ramaddr, 32'h208);
    chk("pr_wb1_dwait", dwait, 2'b01);
    step(); 
    @(negedge CLK);
    chk("pr_wb2_wen", ramWEN, 1'b1);
    chk("pr_wb2_dwait", dwait, 2'b01);
    step(); dWEN = 2'b00;
    @(negedge CLK); chk("pr_idle_wen", ramWEN, 1'b0);
    step();
    @(negedge CLK); chk("pr_snoop_ccwait", ccwait, 2'b10);
    step(); clear_req();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
